// File: rtl/snoop_instr_sequencer.sv
// Instruction FIFO and step sequencer for the snooping coherence datapath.
// Holds each instruction stable for four enabled cycles (step 0..3) and chains queued work without bubbles.
module snoop_instr_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          push,
    input  logic [8:0]    push_instr,
    input  logic          run,
    input  logic          advance,
    output logic [8:0]    instruction,
    output logic [1:0]    step,
    output logic          valid,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          reject,
    output logic          overflow,
    output logic          done,
    output logic [7:0]    issued
);

    typedef enum logic {IDLE, EXEC} state_t;

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [8:0]    mem_q [DEPTH];
    state_t        state_q,    state_d;
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [AW:0]   count_q,    count_d;
    logic [8:0]    instr_q,    instr_d;
    logic [1:0]    step_q,     step_d;
    logic          valid_q,    valid_d;
    logic          reject_q,   reject_d;
    logic          overflow_q, overflow_d;
    logic          done_q,     done_d;
    logic [7:0]    issued_q,   issued_d;

    logic en;
    logic pop;
    logic proc_bad;
    logic push_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    always_comb begin
        en       = run | advance;
        // Emptiness is judged on the registered count, so a same-cycle push to an empty FIFO is never popped.
        pop      = en && !empty && ((state_q == IDLE) || (step_q == 2'd3));
        proc_bad = (push_instr[7:6] == 2'b11);
        push_ok  = push && !proc_bad && (!full || pop);

        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        instr_d    = instr_q;
        step_d     = step_q;
        valid_d    = valid_q;
        reject_d   = 1'b0;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        issued_d   = issued_q;

        if (pop) begin
            instr_d  = mem_q[rd_ptr_q];
            step_d   = 2'd0;
            valid_d  = 1'b1;
            issued_d = issued_q + 8'd1;
            rd_ptr_d = rd_ptr_q + AW'(1);
            state_d  = EXEC;
        end else if (en && state_q == EXEC) begin
            if (step_q != 2'd3) begin
                step_d = step_q + 2'd1;
            end else begin
                step_d  = 2'd0;
                valid_d = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end

        if (push && !push_ok) begin
            reject_d = 1'b1;
            if (!proc_bad) begin
                overflow_d = 1'b1;
            end
        end

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        case ({push_ok, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; the pointers and count define which entries are live.
    always_ff @(posedge clock) begin
        if (resetn && push_ok) begin
            mem_q[wr_ptr_q] <= push_instr;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            instr_q    <= '0;
            step_q     <= '0;
            valid_q    <= 1'b0;
            reject_q   <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            issued_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            instr_q    <= instr_d;
            step_q     <= step_d;
            valid_q    <= valid_d;
            reject_q   <= reject_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            issued_q   <= issued_d;
        end
    end

    assign instruction = instr_q;
    assign step        = step_q;
    assign valid       = valid_q;
    assign count       = count_q;
    assign reject      = reject_q;
    assign overflow    = overflow_q;
    assign done        = done_q;
    assign issued      = issued_q;

endmodule

// File: tb/tb_snoop_instr_sequencer.sv
// Randomized and directed bench for snoop_instr_sequencer, checked every cycle against a queue-based reference model.
module tb_snoop_instr_sequencer;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clock;
    logic          resetn;
    logic          push;
    logic [8:0]    push_instr;
    logic          run;
    logic          advance;
    logic [8:0]    instruction;
    logic [1:0]    step;
    logic          valid;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          reject;
    logic          overflow;
    logic          done;
    logic [7:0]    issued;

    snoop_instr_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .push        (push),
        .push_instr  (push_instr),
        .run         (run),
        .advance     (advance),
        .instruction (instruction),
        .step        (step),
        .valid       (valid),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .reject      (reject),
        .overflow    (overflow),
        .done        (done),
        .issued      (issued)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    // Reference model: the pending program is a plain queue; execution is an instruction plus a phase number.
    int mq[$];
    int m_instr;
    int m_step;
    int m_valid;
    int m_issued;
    int m_reject;
    int m_overflow;
    int m_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("instruction", 32'(instruction), 32'(m_instr));
        check("step",        32'(step),        32'(m_step));
        check("valid",       32'(valid),       32'(m_valid));
        check("count",       32'(count),       32'(mq.size()));
        check("empty",       32'(empty),       32'(mq.size() == 0));
        check("full",        32'(full),        32'(mq.size() == DEPTH));
        check("reject",      32'(reject),      32'(m_reject));
        check("overflow",    32'(overflow),    32'(m_overflow));
        check("done",        32'(done),        32'(m_done));
        check("issued",      32'(issued),      32'(m_issued));
    endtask

    task automatic model_reset();
        mq.delete();
        m_instr = 0; m_step = 0; m_valid = 0; m_issued = 0;
        m_reject = 0; m_overflow = 0; m_done = 0;
    endtask

    // Apply one clock of the sequencing rules to the model, then let the DUT take the same edge and compare.
    task automatic cyc(input logic p, input logic [8:0] pi, input logic r, input logic a);
        int  en;
        int  do_pop;
        int  bad_proc;
        int  accept;
        push = p; push_instr = pi; run = r; advance = a;
        en       = int'(r | a);
        do_pop   = int'(en != 0 && mq.size() > 0 && (m_valid == 0 || m_step == 3));
        bad_proc = int'(pi[7:6] == 2'b11);
        accept   = int'(p && bad_proc == 0 && (mq.size() < DEPTH || do_pop != 0));
        m_reject = 0;
        m_done   = 0;
        if (do_pop != 0) begin
            m_instr  = mq.pop_front();
            m_step   = 0;
            m_valid  = 1;
            m_issued = (m_issued + 1) % 256;
        end else if (en != 0 && m_valid != 0) begin
            if (m_step < 3) begin
                m_step++;
            end else begin
                m_step  = 0;
                m_valid = 0;
                m_done  = 1;
                n_txn++;
                $display("txn %0d: program drained, last instr 0x%03h issued=%0d", n_txn, m_instr, m_issued);
            end
        end
        if (p && accept == 0) begin
            m_reject = 1;
            if (bad_proc == 0) m_overflow = 1;
        end
        if (accept != 0) mq.push_back(int'(pi));
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        push = 1'($urandom); push_instr = 9'($urandom); run = 1'($urandom); advance = 1'($urandom);
        model_reset();
        @(posedge clock);
        #1;
        check_all();
        resetn = 1'b1;
    endtask

    function automatic logic [8:0] good_instr();
        logic [8:0] v;
        v = 9'($urandom);
        if (v[7:6] == 2'b11) v[7:6] = 2'($urandom_range(0, 2));
        return v;
    endfunction

    initial begin
        resetn = 1'b1; push = 0; push_instr = '0; run = 0; advance = 0;
        model_reset();
        @(negedge clock);
        do_reset();

        // Single instruction run end to end.
        cyc(1, 9'h0A5, 1, 0);
        for (int i = 0; i < 6; i++) cyc(0, 9'h000, 1, 0);
        $display("txn phase1: issued=%0d instruction=0x%03h", issued, instruction);

        // Three instructions stepped by isolated advance pulses.
        for (int i = 0; i < 3; i++) cyc(1, good_instr(), 0, 0);
        for (int i = 0; i < 13; i++) begin
            cyc(0, 9'h000, 0, 1);
            cyc(0, 9'h000, 0, 0);
            cyc(0, 9'h000, 0, 0);
        end

        // Fill, overflow, then push every cycle while draining.
        for (int i = 0; i < DEPTH; i++) cyc(1, good_instr(), 0, 0);
        cyc(1, good_instr(), 0, 0);
        for (int i = 0; i < 12; i++) cyc(1, good_instr(), 1, 0);
        for (int i = 0; i < 40; i++) cyc(0, 9'h000, 1, 0);

        // Nonexistent processor after a fresh reset leaves overflow clear.
        do_reset();
        cyc(1, 9'h0C0, 0, 0);
        cyc(0, 9'h000, 0, 0);

        // Reset in the middle of execution with work queued.
        for (int i = 0; i < 5; i++) cyc(1, good_instr(), 0, 0);
        cyc(0, 9'h000, 1, 0);
        cyc(0, 9'h000, 1, 0);
        cyc(0, 9'h000, 1, 0);
        do_reset();
        for (int i = 0; i < 3; i++) cyc(0, 9'h000, 1, 0);

        // 256 single-instruction programs to wrap issued and the pointers.
        for (int k = 0; k < 256; k++) begin
            cyc(1, good_instr(), 0, 0);
            for (int i = 0; i < 5; i++) cyc(0, 9'h000, 1, 0);
        end

        // Free random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                logic [8:0] v;
                v = ($urandom_range(0, 9) == 0) ? 9'($urandom) : good_instr();
                cyc(1'($urandom_range(0, 2) == 0), v,
                    1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
